// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address/byte helpers for data_cache.
package cache_pkg;

    localparam int O    = 4;
    localparam int S    = 5;
    localparam int W    = 2;
    localparam int T    = 32 - O - S;
    localparam int D    = 2**O / 4;
    localparam int WB   = O - 2;
    localparam int SETS = 2**S;

    localparam logic [WB-1:0] LAST_WORD = WB'(D - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        FILL_REQ,
        FILL_WAIT,
        COMPLETE
    } state_e;

    function automatic logic [T-1:0] get_tag(input logic [31:0] addr);
        return addr[31:O+S];
    endfunction

    function automatic logic [S-1:0] get_index(input logic [31:0] addr);
        return addr[O+S-1:O];
    endfunction

    function automatic logic [WB-1:0] get_word(input logic [31:0] addr);
        return addr[O-1:2];
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int unsigned b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid/dirty/tag/data storage with combinational lookup.
module cache_way_array
    import cache_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [S-1:0]         i_index,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic [T-1:0]         o_tag,
    output logic [D-1:0][31:0]   o_line,
    input  logic                 i_data_we,
    input  logic [WB-1:0]        i_word,
    input  logic [3:0]           i_mask,
    input  logic [31:0]          i_wdata,
    input  logic                 i_meta_we,
    input  logic                 i_meta_dirty,
    input  logic [T-1:0]         i_meta_tag
);

    logic [SETS-1:0]       valid_d, valid_q;
    logic [SETS-1:0]       dirty_d, dirty_q;
    logic [T-1:0]          tag_mem  [SETS];
    logic [D-1:0][31:0]    data_mem [SETS];

    assign o_valid = valid_q[i_index];
    assign o_dirty = dirty_q[i_index];
    assign o_tag   = tag_mem[i_index];
    assign o_line  = data_mem[i_index];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (i_meta_we) begin
            valid_d[i_index] = 1'b1;
            dirty_d[i_index] = i_meta_dirty;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage is not reset; valid gates every use of it.
    always_ff @(posedge i_clk) begin
        if (i_meta_we) begin
            tag_mem[i_index] <= i_meta_tag;
        end
        if (i_data_we) begin
            data_mem[i_index][i_word] <= merge_bytes(data_mem[i_index][i_word], i_wdata, i_mask);
        end
    end

endmodule

// File: rtl/data_cache.sv
// 2-way set-associative write-back, write-allocate L1 data cache with NMRU replacement.
module data_cache
    import cache_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_busy,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [3:0]  i_req_mask,
    input  logic [31:0] i_req_wdata,
    output logic [31:0] o_res_rdata
);

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [3:0]         mask_q, mask_d;
    logic               write_q, write_d;
    logic               busy_q, busy_d;
    logic               victim_q, victim_d;
    logic [WB-1:0]      cnt_req_q, cnt_req_d;
    logic [WB-1:0]      cnt_rsp_q, cnt_rsp_d;
    logic [SETS-1:0]    mru_q, mru_d;

    logic [S-1:0]                lookup_index;
    logic [W-1:0]                way_valid, way_dirty, hit;
    logic [W-1:0][T-1:0]         way_tag;
    logic [W-1:0][D-1:0][31:0]   way_line;
    logic [W-1:0]                data_we, meta_we;
    logic [WB-1:0]               arr_word;
    logic [3:0]                  arr_mask;
    logic [31:0]                 arr_wdata;
    logic                        arr_dirty;
    logic [T-1:0]                arr_tag;
    logic                        hit_way, victim;

    assign lookup_index = (state_q == IDLE) ? get_index(i_req_addr) : get_index(addr_q);
    assign o_busy       = busy_q;
    assign o_res_rdata  = rdata_q;

    for (genvar g = 0; g < W; g++) begin : g_way
        cache_way_array u_way (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_index      (lookup_index),
            .o_valid      (way_valid[g]),
            .o_dirty      (way_dirty[g]),
            .o_tag        (way_tag[g]),
            .o_line       (way_line[g]),
            .i_data_we    (data_we[g]),
            .i_word       (arr_word),
            .i_mask       (arr_mask),
            .i_wdata      (arr_wdata),
            .i_meta_we    (meta_we[g]),
            .i_meta_dirty (arr_dirty),
            .i_meta_tag   (arr_tag)
        );
    end

    always_comb begin
        for (int unsigned w = 0; w < W; w++) begin
            hit[w] = way_valid[w] && (way_tag[w] == get_tag(i_req_addr));
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mask_d      = mask_q;
        write_d     = write_q;
        busy_d      = busy_q;
        victim_d    = victim_q;
        cnt_req_d   = cnt_req_q;
        cnt_rsp_d   = cnt_rsp_q;
        mru_d       = mru_q;
        data_we     = '0;
        meta_we     = '0;
        arr_word    = '0;
        arr_mask    = '0;
        arr_wdata   = '0;
        arr_dirty   = 1'b0;
        arr_tag     = '0;
        hit_way     = hit[1];
        victim      = 1'b0;
        o_mem_addr  = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (i_req_wen || i_req_ren) begin
                    if (|hit) begin
                        mru_d[lookup_index] = hit_way;
                        if (i_req_wen) begin
                            data_we[hit_way] = 1'b1;
                            meta_we[hit_way] = 1'b1;
                            arr_word         = get_word(i_req_addr);
                            arr_mask         = i_req_mask;
                            arr_wdata        = i_req_wdata;
                            arr_tag          = get_tag(i_req_addr);
                            arr_dirty        = 1'b1;
                        end else begin
                            rdata_d = way_line[hit_way][get_word(i_req_addr)];
                        end
                    end else begin
                        // Prefer an empty way (way0 first), else evict the not-most-recent one.
                        victim    = !way_valid[0] ? 1'b0 :
                                    !way_valid[1] ? 1'b1 : !mru_q[lookup_index];
                        victim_d  = victim;
                        addr_d    = i_req_addr;
                        write_d   = i_req_wen;
                        mask_d    = i_req_mask;
                        wdata_d   = i_req_wdata;
                        busy_d    = 1'b1;
                        cnt_req_d = '0;
                        cnt_rsp_d = '0;
                        state_d   = (way_valid[victim] && way_dirty[victim]) ? WRITEBACK : FILL_REQ;
                    end
                end
            end

            WRITEBACK: begin
                o_mem_wen   = i_mem_ready;
                o_mem_addr  = {way_tag[victim_q], get_index(addr_q), cnt_req_q, 2'b00};
                o_mem_wdata = way_line[victim_q][cnt_req_q];
                if (i_mem_ready) begin
                    cnt_req_d = cnt_req_q + 1'b1;
                    if (cnt_req_q == LAST_WORD) begin
                        state_d = FILL_REQ;
                    end
                end
            end

            FILL_REQ, FILL_WAIT: begin
                if (state_q == FILL_REQ) begin
                    o_mem_ren  = i_mem_ready;
                    o_mem_addr = {get_tag(addr_q), get_index(addr_q), cnt_req_q, 2'b00};
                    if (i_mem_ready) begin
                        cnt_req_d = cnt_req_q + 1'b1;
                        if (cnt_req_q == LAST_WORD) begin
                            state_d = FILL_WAIT;
                        end
                    end
                end
                // Responses are collected while requests are still being issued.
                if (i_mem_valid) begin
                    data_we[victim_q] = 1'b1;
                    arr_word          = cnt_rsp_q;
                    arr_mask          = '1;
                    arr_wdata         = i_mem_rdata;
                    cnt_rsp_d         = cnt_rsp_q + 1'b1;
                    if (state_q == FILL_WAIT && cnt_rsp_q == LAST_WORD) begin
                        state_d = COMPLETE;
                    end
                end
            end

            COMPLETE: begin
                meta_we[victim_q] = 1'b1;
                arr_tag           = get_tag(addr_q);
                arr_dirty         = write_q;
                if (write_q) begin
                    data_we[victim_q] = 1'b1;
                    arr_word          = get_word(addr_q);
                    arr_mask          = mask_q;
                    arr_wdata         = wdata_q;
                end else begin
                    rdata_d = way_line[victim_q][get_word(addr_q)];
                end
                mru_d[lookup_index] = victim_q;
                busy_d              = 1'b0;
                state_d             = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mask_q    <= '0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            victim_q  <= 1'b0;
            cnt_req_q <= '0;
            cnt_rsp_q <= '0;
            mru_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mask_q    <= mask_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            victim_q  <= victim_d;
            cnt_req_q <= cnt_req_d;
            cnt_rsp_q <= cnt_rsp_d;
            mru_q     <= mru_d;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed sequences, a vector table and random traffic.
module tb_data_cache;

    localparam int LAT = 4;
    localparam int IVL = 2;

    logic        clk, rst;
    logic        mem_ready, mem_ren, mem_wen, mem_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;
    logic [31:0] req_addr, req_wdata, res_rdata;
    logic        req_ren, req_wen;
    logic [3:0]  req_mask;

    data_cache dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_ready (mem_ready),
        .o_mem_addr  (mem_addr),
        .o_mem_ren   (mem_ren),
        .o_mem_wen   (mem_wen),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_valid (mem_valid),
        .o_busy      (busy),
        .i_req_addr  (req_addr),
        .i_req_ren   (req_ren),
        .i_req_wen   (req_wen),
        .i_req_mask  (req_mask),
        .i_req_wdata (req_wdata),
        .o_res_rdata (res_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endfunction

    // ---------------- main memory model ----------------
    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic [31:0] mem     [2048];
    logic [31:0] ref_mem [2048];
    rsp_t        rsp_q [$];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log [$];
    logic [31:0] wr_dlog [$];
    int          rd_cnt = 0, wr_cnt = 0, hs_viol = 0, cyc = 0, gap = 0;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h13579BDF;
    endfunction

    initial begin
        rsp_t r;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_valid = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                mem_valid = 1'b1;
                mem_rdata = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end
            mem_ready = (gap == 0);
            #1;
            if (!mem_ready && (mem_ren || mem_wen)) hs_viol++;
            if (mem_ren && mem_wen) hs_viol++;
            if (mem_ready && mem_ren) begin
                r.data = mem[mem_addr[12:2]];
                r.due  = cyc + LAT;
                rsp_q.push_back(r);
                rd_log.push_back(mem_addr);
                rd_cnt++;
                gap = IVL - 1;
            end else if (mem_ready && mem_wen) begin
                mem[mem_addr[12:2]] = mem_wdata;
                wr_log.push_back(mem_addr);
                wr_dlog.push_back(mem_wdata);
                wr_cnt++;
                gap = IVL - 1;
            end else if (gap > 0) begin
                gap--;
            end
        end
    end

    // ---------------- reference cache model (per-set LRU list, entry 0 = most recent) ----------------
    int mt [32][2];
    bit mv [32][2];
    bit md [32][2];

    function automatic void model_reset();
        for (int s = 0; s < 32; s++) begin
            for (int e = 0; e < 2; e++) begin
                mv[s][e] = 1'b0;
                md[s][e] = 1'b0;
                mt[s][e] = 0;
            end
        end
        for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
    endfunction

    function automatic void model_access(input logic [31:0] a, input bit w, input logic [3:0] m,
                                         input logic [31:0] d, output bit miss, output bit wb,
                                         output logic [31:0] rd);
        int s, t, wi, tt;
        bit tv, td;
        s    = int'(a[8:4]);
        t    = int'(a[31:9]);
        wi   = int'(a[12:2]);
        miss = 1'b0;
        wb   = 1'b0;
        if (mv[s][0] && mt[s][0] == t) begin
        end else if (mv[s][1] && mt[s][1] == t) begin
            tt = mt[s][0]; tv = mv[s][0]; td = md[s][0];
            mt[s][0] = mt[s][1]; mv[s][0] = mv[s][1]; md[s][0] = md[s][1];
            mt[s][1] = tt; mv[s][1] = tv; md[s][1] = td;
        end else begin
            miss = 1'b1;
            wb   = mv[s][1] && md[s][1];
            mt[s][1] = mt[s][0]; mv[s][1] = mv[s][0]; md[s][1] = md[s][0];
            mt[s][0] = t; mv[s][0] = 1'b1; md[s][0] = 1'b0;
        end
        if (w) begin
            md[s][0] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (m[b]) ref_mem[wi][8*b +: 8] = d[8*b +: 8];
            end
        end
        rd = ref_mem[wi];
    endfunction

    // ---------------- request helpers ----------------
    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_req(input logic [31:0] a, input bit w, input logic [3:0] m, input logic [31:0] d,
                          output bit miss, output int rds, output int wrs, output logic [31:0] rdat);
        int r0, w0, n;
        @(negedge clk);
        r0 = rd_cnt;
        w0 = wr_cnt;
        req_addr  = a;
        req_ren   = !w;
        req_wen   = w;
        req_mask  = m;
        req_wdata = d;
        @(negedge clk);
        req_ren = 1'b0;
        req_wen = 1'b0;
        miss = busy;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", busy, 0);
        rds  = rd_cnt - r0;
        wrs  = wr_cnt - w0;
        rdat = res_rdata;
    endtask

    task automatic access(input string nm, input logic [31:0] a, input bit w, input logic [3:0] m,
                          input logic [31:0] d, output bit miss, output logic [31:0] rdat);
        bit emiss, ewb;
        logic [31:0] erd;
        int rds, wrs;
        model_access(a, w, m, d, emiss, ewb, erd);
        do_req(a, w, m, d, miss, rds, wrs, rdat);
        chk({nm, "_miss"}, 32'(miss), 32'(emiss));
        chk({nm, "_memwr"}, wrs, ewb ? 4 : 0);
        chk({nm, "_memrd"}, rds, emiss ? 4 : 0);
        if (!w) chk({nm, "_rdata"}, rdat, erd);
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          wen;
        logic [3:0]  mask;
        logic [31:0] wdata;
        bit          exp_miss;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [16];

    initial begin
        bit          miss;
        logic [31:0] rdat, a, d;
        int          base, n, rd0;
        bit          w;
        logic [3:0]  m;

        req_addr = '0; req_ren = 1'b0; req_wen = 1'b0; req_mask = '0; req_wdata = '0;
        for (int i = 0; i < 2048; i++) mem[i] = init_word(i);

        tbl[0]  = '{32'h200, 1'b1, 4'hF, 32'h00000000, 1'b1, 32'h0};
        tbl[1]  = '{32'h204, 1'b1, 4'hF, 32'h11111111, 1'b0, 32'h0};
        tbl[2]  = '{32'h208, 1'b1, 4'hF, 32'h22222222, 1'b0, 32'h0};
        tbl[3]  = '{32'h20C, 1'b1, 4'hF, 32'h33333333, 1'b0, 32'h0};
        tbl[4]  = '{32'h400, 1'b1, 4'hF, 32'h44444444, 1'b1, 32'h0};
        tbl[5]  = '{32'h404, 1'b1, 4'hF, 32'h55555555, 1'b0, 32'h0};
        tbl[6]  = '{32'h408, 1'b1, 4'hF, 32'h66666666, 1'b0, 32'h0};
        tbl[7]  = '{32'h40C, 1'b1, 4'hF, 32'h77777777, 1'b0, 32'h0};
        tbl[8]  = '{32'h200, 1'b0, 4'h0, 32'h0, 1'b0, 32'h00000000};
        tbl[9]  = '{32'h204, 1'b0, 4'h0, 32'h0, 1'b0, 32'h11111111};
        tbl[10] = '{32'h208, 1'b0, 4'h0, 32'h0, 1'b0, 32'h22222222};
        tbl[11] = '{32'h20C, 1'b0, 4'h0, 32'h0, 1'b0, 32'h33333333};
        tbl[12] = '{32'h400, 1'b0, 4'h0, 32'h0, 1'b0, 32'h44444444};
        tbl[13] = '{32'h404, 1'b0, 4'h0, 32'h0, 1'b0, 32'h55555555};
        tbl[14] = '{32'h408, 1'b0, 4'h0, 32'h0, 1'b0, 32'h66666666};
        tbl[15] = '{32'h40C, 1'b0, 4'h0, 32'h0, 1'b0, 32'h77777777};

        reset_dut();
        chk("rst_busy",  32'(busy), 0);
        chk("rst_ren",   32'(mem_ren), 0);
        chk("rst_wen",   32'(mem_wen), 0);
        chk("rst_addr",  mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", res_rdata, 0);

        // Cold read miss then hits on the same line.
        base = rd_log.size();
        access("rd0", 32'h0, 1'b0, 4'hF, 32'h0, miss, rdat);
        chk("rd0_busy", 32'(miss), 1);
        chk("rd0_data", rdat, init_word(0));
        for (int i = 0; i < 4; i++) chk("rd0_fill_addr", rd_log[base + i], 32'(4 * i));
        access("rd0_again", 32'h0, 1'b0, 4'hF, 32'h0, miss, rdat);
        chk("rd0_again_busy", 32'(miss), 0);
        chk("rd0_again_data", rdat, init_word(0));
        access("rdA", 32'hA, 1'b0, 4'h0, 32'h0, miss, rdat);
        chk("rdA_busy", 32'(miss), 0);
        chk("rdA_data", rdat, init_word(2));

        // Write-allocate then write hit.
        base = rd_log.size();
        access("wr200", 32'h200, 1'b1, 4'hF, 32'hDEADBEEF, miss, rdat);
        chk("wr200_busy", 32'(miss), 1);
        for (int i = 0; i < 4; i++) chk("wr200_fill_addr", rd_log[base + i], 32'h200 + 32'(4 * i));
        access("wr200_hit", 32'h200, 1'b1, 4'hF, 32'hBEEFCAFE, miss, rdat);
        chk("wr200_hit_busy", 32'(miss), 0);
        access("rd200", 32'h200, 1'b0, 4'hF, 32'h0, miss, rdat);
        chk("rd200_data", rdat, 32'hBEEFCAFE);

        // Evictions: clean victim first, then the dirty one.
        base = wr_log.size();
        access("wr400", 32'h400, 1'b1, 4'hF, 32'hCAFEBEEF, miss, rdat);
        chk("wr400_busy", 32'(miss), 1);
        chk("wr400_no_wb", wr_log.size(), base);
        access("rd0_evict", 32'h0, 1'b0, 4'hF, 32'h0, miss, rdat);
        chk("rd0_evict_busy", 32'(miss), 1);
        chk("rd0_evict_nwr", wr_log.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("rd0_evict_wb_addr", wr_log[base + i], 32'h200 + 32'(4 * i));
        chk("rd0_evict_wb_data", wr_dlog[base], 32'hBEEFCAFE);
        chk("rd0_evict_data", rdat, init_word(0));
        access("rd200_refetch", 32'h200, 1'b0, 4'hF, 32'h0, miss, rdat);
        chk("rd200_refetch_busy", 32'(miss), 1);
        chk("rd200_refetch_data", rdat, 32'hBEEFCAFE);

        // Masked writes.
        access("wr_full", 32'h200, 1'b1, 4'hF, 32'h11111111, miss, rdat);
        access("wr_hi", 32'h200, 1'b1, 4'b1100, 32'hBEEF0000, miss, rdat);
        access("rd_hi", 32'h200, 1'b0, 4'hF, 32'h0, miss, rdat);
        chk("mask_hi_data", rdat, 32'hBEEF1111);
        access("wr_lo", 32'h200, 1'b1, 4'b0011, 32'h0000CAFE, miss, rdat);
        access("rd_lo", 32'h200, 1'b0, 4'hF, 32'h0, miss, rdat);
        chk("mask_lo_data", rdat, 32'hBEEFCAFE);

        // Vector table: fill both ways of set 0 after reset.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            access("tbl", tbl[i].addr, tbl[i].wen, tbl[i].mask, tbl[i].wdata, miss, rdat);
            chk("tbl_miss_const", 32'(miss), 32'(tbl[i].exp_miss));
            if (!tbl[i].wen) chk("tbl_rdata_const", rdat, tbl[i].exp_rdata);
        end

        // Reset while fill responses are outstanding.
        @(negedge clk);
        rd0 = rd_cnt;
        req_addr = 32'h1010; req_ren = 1'b1; req_wen = 1'b0; req_mask = 4'hF;
        @(negedge clk);
        req_ren = 1'b0;
        n = 0;
        while (rd_cnt - rd0 < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midfill_issued", 32'(rd_cnt - rd0 >= 4), 1);
        #2 rst = 1'b1;
        #1;
        chk("midfill_rst_busy", 32'(busy), 0);
        chk("midfill_rst_ren", 32'(mem_ren), 0);
        chk("midfill_rst_wen", 32'(mem_wen), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        chk("midfill_idle_busy", 32'(busy), 0);
        access("rd1010", 32'h1010, 1'b0, 4'hF, 32'h0, miss, rdat);
        chk("rd1010_busy", 32'(miss), 1);
        chk("rd1010_data", rdat, init_word(32'h1010 >> 2));

        // Random traffic over a few tags and sets to force conflicts and write-backs.
        for (int i = 0; i < 400; i++) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            m = 4'($urandom);
            d = $urandom;
            access("rnd", a, w, m, d, miss, rdat);
        end

        chk("handshake_viol", hs_viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
